// File: rtl/fifo_pop_pkg.sv
// Shared definitions for the FIFO read-side pop controller.
// State encodings and a constant log2 helper for pointer sizing.
package fifo_pop_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STREAM  = 2'd1;
    localparam logic [1:0] ST_TRICKLE = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_STREAM  = ST_STREAM,
        S_TRICKLE = ST_TRICKLE,
        S_WAIT    = ST_WAIT
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pop_skid_buf.sv
// Circular landing buffer for words returned by the FIFO.
// Head word falls through to rd_data; valid whenever count is non-zero.
module pop_skid_buf
    import fifo_pop_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 4,
    parameter int PW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic [PW:0]           count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_ok;

    assign valid   = (count != '0);
    assign rd_ok   = rd & valid;
    assign rd_data = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Read-side pop controller: credit-gated pops, tagged capture, stream out.
// Optional word counter output enabled by defining POP_CTRL_STATS_EN.
module fifo_pop_ctrl
    import fifo_pop_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int READ_LATENCY = 2,
    parameter int FLAG_LAG     = 3,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo,
    input  logic                  almost_empty_fifo,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
`ifdef POP_CTRL_STATS_EN
    output logic [15:0]           word_cnt,
`endif
    output logic [1:0]            state_o
);

    localparam int PW = clog2(BUF_DEPTH);
    localparam int CW = PW + 2;
    localparam int WW = clog2(FLAG_LAG) + 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(FLAG_LAG - 1);

    state_t                  state;
    logic [WW-1:0]           wcnt;
    logic [READ_LATENCY-1:0] tags;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           need;
    logic [PW:0]             count;
    logic                    credit_ok;
    logic                    buf_wr;
    logic                    buf_rd;

    assign buf_wr = tags[READ_LATENCY-1];
    assign buf_rd = out_valid & out_ready;

    // Count tags still travelling through the FIFO read pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(tags[i]);
        end
    end

    // Pop issued now and word leaving now are both counted, so the
    // next pop can never land in a full buffer.
    assign need      = CW'(count) + inflight + CW'(pop) - CW'(buf_rd);
    assign credit_ok = (need < CW'(BUF_DEPTH));

    // Tag shift register marks which cycles carry returning data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tags <= '0;
        else       tags <= (tags << 1) | READ_LATENCY'(pop);
    end

    // Pop FSM; the wait counter starts in the pop cycle so re-evaluation
    // happens exactly when the flags have caught up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pop   <= 1'b0;
            wcnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    pop <= 1'b0;
                    if (enable & ~empty_fifo & ~almost_empty_fifo) begin
                        state <= S_STREAM;
                    end else if (enable & ~empty_fifo) begin
                        state <= S_TRICKLE;
                        pop   <= credit_ok;
                        wcnt  <= WAIT_LOAD;
                    end
                end
                S_STREAM: begin
                    if (~enable | empty_fifo) begin
                        state <= S_IDLE;
                        pop   <= 1'b0;
                    end else if (almost_empty_fifo) begin
                        state <= S_TRICKLE;
                        pop   <= 1'b0;
                        wcnt  <= WAIT_LOAD;
                    end else begin
                        pop <= credit_ok;
                    end
                end
                S_TRICKLE: begin
                    if (pop) begin
                        state <= S_WAIT;
                        pop   <= 1'b0;
                        wcnt  <= (wcnt == '0) ? '0 : wcnt - 1'b1;
                    end else if (~enable) begin
                        state <= S_IDLE;
                    end else begin
                        pop  <= credit_ok;
                        wcnt <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    pop <= 1'b0;
                    if (wcnt == '0) state <= S_IDLE;
                    else            wcnt  <= wcnt - 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    pop   <= 1'b0;
                end
            endcase
        end
    end

    pop_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .PW         (PW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (buf_wr),
        .wr_data (fifo_data),
        .rd      (buf_rd),
        .rd_data (out_data),
        .valid   (out_valid),
        .count   (count)
    );

    assign state_o = state;
    assign busy    = (state != S_IDLE) | (|tags) | pop | out_valid;

`ifdef POP_CTRL_STATS_EN
    // Saturating count of accepted output words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             word_cnt <= '0;
        else if (buf_rd && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 1'b1;
    end
`endif

endmodule
